// File: rtl/chs_power_ramp_ctrl_pkg.sv
// Shared types and helpers for the heater/cooler power ramp controller.
package chs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_DEAD = 2'd2,
    ST_UP   = 2'd3
  } chs_state_e;

  localparam logic MODE_HEAT = 1'b1;
  localparam logic MODE_COOL = 1'b0;

  // Bits needed to hold a popcount of a conf_w-bit word.
  function automatic int unsigned chs_pwr_width(input int unsigned conf_w);
    return $clog2(conf_w + 1);
  endfunction

endpackage

// File: rtl/chs_power_ramp_ctrl_popcount.sv
// Combinational popcount and parity of the configuration word.
module chs_popcount #(
  parameter int unsigned CONF_W = 8,
  parameter int unsigned PWR_W  = 4
) (
  input  logic [CONF_W-1:0] conf,
  output logic [PWR_W-1:0]  cnt,
  output logic              parity
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < CONF_W; i++) begin
      cnt = cnt + PWR_W'(conf[i]);
    end
  end

  assign parity = ^conf;

endmodule

// File: rtl/chs_power_ramp_ctrl.sv
// Heater/cooler power ramp controller: steps power toward popcount target, zero-power dead time on mode flips.
// Optional clamp of the target power to MAX_PWR when CHS_SAT_LIMIT_EN is defined.
module chs_power_ramp_ctrl
  import chs_pkg::*;
#(
  parameter int unsigned CONF_W   = 8,
  parameter int unsigned PWR_W    = chs_pwr_width(CONF_W),
  parameter int unsigned RAMP_DIV = 4,
  parameter int unsigned DEAD_CYC = 3,
  parameter int unsigned MAX_PWR  = CONF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_valid,
  output logic              conf_ready,
  input  logic [CONF_W-1:0] chs_conf,
  output logic [PWR_W-1:0]  chs_power,
  output logic              chs_mode,
  output logic              chs_busy,
  output logic              chs_done
);

  localparam int unsigned PRESC_W = $clog2(RAMP_DIV + 1);
  localparam int unsigned DEAD_W  = $clog2(DEAD_CYC + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYC - 1);

  chs_state_e         state;
  logic [PWR_W-1:0]   tpwr;
  logic               tmode;
  logic [PRESC_W-1:0] presc;
  logic [DEAD_W-1:0]  dead_cnt;

  logic [PWR_W-1:0]   pop_cnt;
  logic               pop_par;
  logic [PWR_W-1:0]   new_tpwr;
  logic               new_tmode;
  logic [PWR_W-1:0]   step_pwr;
  chs_state_e         acc_state;
  chs_state_e         step_state;

  chs_popcount #(
    .CONF_W (CONF_W),
    .PWR_W  (PWR_W)
  ) u_popcount (
    .conf   (chs_conf),
    .cnt    (pop_cnt),
    .parity (pop_par)
  );

`ifdef CHS_SAT_LIMIT_EN
  assign new_tpwr = (pop_cnt > PWR_W'(MAX_PWR)) ? PWR_W'(MAX_PWR) : pop_cnt;
`else
  assign new_tpwr = pop_cnt;
`endif
  assign new_tmode = pop_par ? MODE_HEAT : MODE_COOL;

  function automatic chs_state_e decide(input logic mode, input logic [PWR_W-1:0] pwr,
                                        input logic t_mode, input logic [PWR_W-1:0] t_pwr);
    if (mode != t_mode) return (pwr != '0) ? ST_DOWN : ST_DEAD;
    if (t_pwr < pwr)    return ST_DOWN;
    if (t_pwr > pwr)    return ST_UP;
    return ST_IDLE;
  endfunction

  // The state after a ramp step is decided on the already-stepped power.
  always_comb begin
    step_pwr   = (state == ST_UP) ? chs_power + PWR_W'(1) : chs_power - PWR_W'(1);
    step_state = decide(chs_mode, step_pwr, tmode, tpwr);
    acc_state  = decide(chs_mode, chs_power, new_tmode, new_tpwr);
  end

  assign conf_ready = (state != ST_DEAD);
  assign chs_busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      chs_power <= '0;
      chs_mode  <= MODE_COOL;
      tpwr      <= '0;
      tmode     <= MODE_COOL;
      presc     <= '0;
      dead_cnt  <= '0;
      chs_done  <= 1'b0;
    end else begin
      chs_done <= 1'b0;
      if (conf_valid && conf_ready) begin
        tpwr     <= new_tpwr;
        tmode    <= new_tmode;
        presc    <= '0;
        dead_cnt <= '0;
        state    <= acc_state;
        chs_done <= (acc_state == ST_IDLE);
      end else begin
        case (state)
          ST_DOWN, ST_UP: begin
            if (presc == PRESC_LAST) begin
              presc     <= '0;
              dead_cnt  <= '0;
              chs_power <= step_pwr;
              state     <= step_state;
              chs_done  <= (step_state == ST_IDLE);
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
          ST_DEAD: begin
            if (dead_cnt == DEAD_LAST) begin
              dead_cnt <= '0;
              presc    <= '0;
              chs_mode <= tmode;
              state    <= (tpwr != '0) ? ST_UP : ST_IDLE;
              chs_done <= (tpwr == '0);
            end else begin
              dead_cnt <= dead_cnt + DEAD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
